t09_cell_painter: RTL and testbench

- Downstream consumer of the grid-cell change stream: one (x, y, obj_code, diff) update per cell.
- Queues changed cells in a small FIFO and repaints each one as a solid CELL_PX x CELL_PX square on an ILI9341-class LCD over an 8-bit 8080 write-only bus.
- Per cell it sends column-address-set, page-address-set and memory-write, then the RGB565 pixels.
- Sits between the frame tracker and the LCD pins. Display initialisation is done by a separate block, signalled by init_done.

---
 rtl/t09_painter_pkg.sv | 57 +++++
 rtl/t09_cell_fifo.sv | 80 ++++++++
 rtl/t09_cell_painter.sv | 212 +++++++++++++++++++++
 tb/tb_t09_cell_painter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t09_painter_pkg.sv
// ---------------------------------------------------------------------------
// t09_painter_pkg
//   Shared definitions for the cell painter: FSM state encoding, ILI9341
//   command bytes, RGB565 colour constants, obj_code encodings (shared with
//   the frame tracker) and the packed layout of one queued cell update.
//   obj_color() maps an obj_code to its solid RGB565 fill colour.
// ---------------------------------------------------------------------------
package t09_painter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_CASET,
        ST_PASET,
        ST_RAMWR,
        ST_PIXELS,
        ST_DONE
    } state_e;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [2:0] OBJ_EMPTY  = 3'b000;
    localparam logic [2:0] OBJ_HEAD   = 3'b001;
    localparam logic [2:0] OBJ_BODY   = 3'b010;
    localparam logic [2:0] OBJ_APPLE  = 3'b011;
    localparam logic [2:0] OBJ_BORDER = 3'b100;

    localparam logic [15:0] COLOR_BLACK  = 16'h0000;
    localparam logic [15:0] COLOR_HEAD   = 16'h07E0;
    localparam logic [15:0] COLOR_BODY   = 16'h03E0;
    localparam logic [15:0] COLOR_APPLE  = 16'hF800;
    localparam logic [15:0] COLOR_BORDER = 16'hFFFF;
    localparam logic [15:0] GRID_COLOR   = 16'h2104;

    // One queued update: 4-bit column, 4-bit row, 3-bit object code.
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] obj;
    } cell_entry_t;

    localparam int ENTRY_W = $bits(cell_entry_t);

    function automatic logic [15:0] obj_color(input logic [2:0] obj);
        case (obj)
            OBJ_EMPTY:  obj_color = COLOR_BLACK;
            OBJ_HEAD:   obj_color = COLOR_HEAD;
            OBJ_BODY:   obj_color = COLOR_BODY;
            OBJ_APPLE:  obj_color = COLOR_APPLE;
            OBJ_BORDER: obj_color = COLOR_BORDER;
            default:    obj_color = COLOR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/t09_cell_fifo.sv
// ---------------------------------------------------------------------------
// t09_cell_fifo
//   Synchronous show-ahead FIFO of cell updates (ENTRY_W-bit entries).
//   A push is accepted when not full, or when a pop happens in the same cycle.
//   A pop on an empty FIFO is ignored.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, din     write request and entry
//   pop           read request; dout always presents the head entry
//   full, empty   status flags
//   count         number of stored entries (0..FIFO_DEPTH)
// ---------------------------------------------------------------------------
module t09_cell_fifo
    import t09_painter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ENTRY_W-1:0]           din,
    input  logic                         pop,
    output logic [ENTRY_W-1:0]           dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               do_push, do_pop;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is not reset; the pointers and count alone
    // decide which entries are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/t09_cell_painter.sv
// ---------------------------------------------------------------------------
// t09_cell_painter
//   Queues changed grid cells and repaints each as a solid CELL_PX x CELL_PX
//   square on an ILI9341-class LCD over an 8-bit 8080 write-only bus:
//   CASET + 4 bytes, PASET + 4 bytes, RAMWR, then CELL_PX^2 RGB565 pixels
//   (high byte first). Every bus byte takes 2 clk: phase A drives data with
//   wrx low, phase B raises wrx with data held.
//   Optional feature: define T09_PAINTER_GRIDLINE_EN to draw the last pixel
//   column and row of each cell in GRID_COLOR (border cells excepted).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   init_done        LCD initialised; gates the start of each transaction
//   diff, x, y,      cell-update strobe and payload; y >= GRID_ROWS ignored
//   obj_code
//   lcd_data/dcx/    8080 bus byte, command(0)/data(1), write strobe (low),
//   wrx/csx          chip select (low)
//   busy             FSM active or updates pending
//   overflow         sticky: an update was dropped on a full FIFO
// ---------------------------------------------------------------------------
module t09_cell_painter
    import t09_painter_pkg::*;
#(
    parameter int CELL_PX    = 20,
    parameter int FIFO_DEPTH = 4,
    parameter int GRID_ROWS  = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       diff,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] obj_code,
    output logic [7:0] lcd_data,
    output logic       lcd_dcx,
    output logic       lcd_wrx,
    output logic       lcd_csx,
    output logic       busy,
    output logic       overflow
);

    localparam int PW = $clog2(CELL_PX);
    localparam logic [PW-1:0] LAST_PX = PW'(CELL_PX - 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    cell_entry_t   cell_q, cell_d;
    logic          phase_q, phase_d;        // 0 = phase A (wrx low), 1 = phase B
    logic [2:0]    byte_idx_q, byte_idx_d;  // byte within CASET/PASET; bit 0 = low pixel byte
    logic [PW-1:0] col_q, col_d;
    logic [PW-1:0] row_q, row_d;
    logic          overflow_q, overflow_d;

    logic          push_req, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    cell_entry_t   fifo_dout, push_entry;

    logic          in_byte;
    logic [15:0]   coord_s, coord_e, pix_color;
    logic [7:0]    byte_data;
    logic          byte_dcx;

    // ---------------- update queue ----------------
    assign push_req   = diff && (32'(y) < GRID_ROWS);
    assign push_entry = '{x: x, y: y, obj: obj_code};
    assign fifo_pop   = (state_q == ST_POP);

    t09_cell_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A full FIFO still accepts a push in the cycle it pops.
    assign overflow_d = overflow_q || (push_req && fifo_full && !fifo_pop);

    // ---------------- byte generation ----------------
    always_comb begin
        // CASET and PASET share one window formula; only the source differs.
        coord_s = (state_q == ST_PASET) ? 16'(cell_q.y) * 16'(CELL_PX)
                                        : 16'(cell_q.x) * 16'(CELL_PX);
        coord_e = coord_s + 16'(CELL_PX - 1);

        pix_color = obj_color(cell_q.obj);
`ifdef T09_PAINTER_GRIDLINE_EN
        if ((col_q == LAST_PX || row_q == LAST_PX) && cell_q.obj != OBJ_BORDER) begin
            pix_color = GRID_COLOR;
        end
`endif

        byte_data = 8'h00;
        byte_dcx  = 1'b1;
        case (state_q)
            ST_CASET, ST_PASET: begin
                case (byte_idx_q)
                    3'd0: begin
                        byte_data = (state_q == ST_PASET) ? CMD_PASET : CMD_CASET;
                        byte_dcx  = 1'b0;
                    end
                    3'd1:    byte_data = coord_s[15:8];
                    3'd2:    byte_data = coord_s[7:0];
                    3'd3:    byte_data = coord_e[15:8];
                    default: byte_data = coord_e[7:0];
                endcase
            end
            ST_RAMWR: begin
                byte_data = CMD_RAMWR;
                byte_dcx  = 1'b0;
            end
            ST_PIXELS: byte_data = byte_idx_q[0] ? pix_color[7:0] : pix_color[15:8];
            default: ;
        endcase
    end

    assign in_byte  = (state_q == ST_CASET) || (state_q == ST_PASET) ||
                      (state_q == ST_RAMWR) || (state_q == ST_PIXELS);
    assign lcd_data = byte_data;
    assign lcd_dcx  = byte_dcx;
    assign lcd_wrx  = !(in_byte && !phase_q);
    assign lcd_csx  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
    assign overflow = overflow_q;

    // ---------------- sequencing ----------------
    always_comb begin
        state_d    = state_q;
        cell_d     = cell_q;
        phase_d    = in_byte ? !phase_q : 1'b0;
        byte_idx_d = byte_idx_q;
        col_d      = col_q;
        row_d      = row_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && init_done) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                cell_d     = fifo_dout;
                byte_idx_d = '0;
                col_d      = '0;
                row_d      = '0;
                state_d    = ST_CASET;
            end
            ST_CASET, ST_PASET: begin
                if (phase_q) begin
                    if (byte_idx_q == 3'd4) begin
                        byte_idx_d = '0;
                        state_d    = (state_q == ST_CASET) ? ST_PASET : ST_RAMWR;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            ST_RAMWR: begin
                if (phase_q) begin
                    state_d = ST_PIXELS;
                end
            end
            ST_PIXELS: begin
                if (phase_q) begin
                    byte_idx_d = byte_idx_q ^ 3'd1;
                    // Advance the pixel position after its low byte.
                    if (byte_idx_q[0]) begin
                        if (col_q == LAST_PX) begin
                            col_d = '0;
                            if (row_q == LAST_PX) begin
                                state_d = ST_DONE;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cell_q     <= '0;
            phase_q    <= 1'b0;
            byte_idx_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cell_q     <= cell_d;
            phase_q    <= phase_d;
            byte_idx_q <= byte_idx_d;
            col_q      <= col_d;
            row_q      <= row_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_t09_cell_painter.sv
// ---------------------------------------------------------------------------
// tb_t09_cell_painter
//   Self-checking bench for t09_cell_painter. A bus monitor collects every
//   written byte and every chip-select low period; a reference model builds
//   each expected cell transaction from the window arithmetic and the colour
//   table. Honours T09_PAINTER_GRIDLINE_EN in its model.
// ---------------------------------------------------------------------------
module tb_t09_cell_painter;

    localparam int CELL_PX     = 20;
    localparam int FIFO_DEPTH  = 4;
    localparam int GRID_ROWS   = 12;
    localparam int TXN_BYTES   = 11 + 2 * CELL_PX * CELL_PX;
    localparam int TXN_CSX_LOW = 1 + 2 * TXN_BYTES;   // POP cycle + all byte cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done = 1'b0;
    logic       diff = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic [2:0] obj_code = '0;
    logic [7:0] lcd_data;
    logic       lcd_dcx, lcd_wrx, lcd_csx, busy, overflow;

    always #5 clk = ~clk;

    t09_cell_painter #(
        .CELL_PX    (CELL_PX),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GRID_ROWS  (GRID_ROWS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .diff      (diff),
        .x         (x),
        .y         (y),
        .obj_code  (obj_code),
        .lcd_data  (lcd_data),
        .lcd_dcx   (lcd_dcx),
        .lcd_wrx   (lcd_wrx),
        .lcd_csx   (lcd_csx),
        .busy      (busy),
        .overflow  (overflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- bus monitor ----------------
    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];
    int         csx_len_q[$];
    int         csx_run = 0;
    int         hold_viol = 0;
    int         stray = 0;
    logic       prev_wrx = 1'b1;
    logic       prev_csx = 1'b1;
    logic [8:0] prev_byte = '0;

    always @(negedge clk) begin
        if (lcd_csx === 1'b0 && lcd_wrx === 1'b0) obs_q.push_back({lcd_dcx, lcd_data});
        if (lcd_csx === 1'b1 && lcd_wrx === 1'b0) stray++;
        // A byte spans exactly two cycles: wrx back high, same data and dcx.
        if (prev_wrx === 1'b0 && lcd_csx === 1'b0 &&
            (lcd_wrx !== 1'b1 || {lcd_dcx, lcd_data} !== prev_byte)) hold_viol++;
        if (lcd_csx === 1'b0) begin
            csx_run++;
        end else if (prev_csx === 1'b0) begin
            csx_len_q.push_back(csx_run);
            csx_run = 0;
        end
        prev_wrx  = lcd_wrx;
        prev_csx  = lcd_csx;
        prev_byte = {lcd_dcx, lcd_data};
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] model_color(input int obj, input int r, input int c);
        logic [15:0] col;
        case (obj)
            1:       col = 16'h07E0;
            2:       col = 16'h03E0;
            3:       col = 16'hF800;
            4:       col = 16'hFFFF;
            default: col = 16'h0000;
        endcase
`ifdef T09_PAINTER_GRIDLINE_EN
        if (obj != 4 && (r == CELL_PX - 1 || c == CELL_PX - 1)) col = 16'h2104;
`endif
        return col;
    endfunction

    task automatic push_word(input int v);
        exp_q.push_back({1'b1, 8'((v >> 8) & 255)});
        exp_q.push_back({1'b1, 8'(v & 255)});
    endtask

    task automatic expect_cell(input int cx, input int cy, input int obj);
        int px0, py0;
        px0 = cx * CELL_PX;
        py0 = cy * CELL_PX;
        exp_q.push_back({1'b0, 8'h2A});
        push_word(px0);
        push_word(px0 + CELL_PX - 1);
        exp_q.push_back({1'b0, 8'h2B});
        push_word(py0);
        push_word(py0 + CELL_PX - 1);
        exp_q.push_back({1'b0, 8'h2C});
        for (int r = 0; r < CELL_PX; r++)
            for (int c = 0; c < CELL_PX; c++)
                push_word(int'(model_color(obj, r, c)));
    endtask

    task automatic compare_txn(input string tag);
        int         len;
        int         bad;
        logic [8:0] o, e, o_sel, e_sel;
        bad = -1;
        o_sel = '0;
        e_sel = '0;
        len = -1;
        if (csx_len_q.size() > 0) len = csx_len_q.pop_front();
        check({tag, " csx_low_cycles"}, len, TXN_CSX_LOW);
        for (int i = 0; i < TXN_BYTES; i++) begin
            e = 9'h1FF;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            o = 9'bx;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            if (bad < 0 && o !== e) begin
                bad = i;
                o_sel = o;
                e_sel = e;
            end else if (bad < 0 && i == TXN_BYTES - 1) begin
                o_sel = o;
                e_sel = e;
            end
        end
        check($sformatf("%s byte[%0d] {dcx,data}", tag, (bad < 0) ? TXN_BYTES - 1 : bad), o_sel, e_sel);
    endtask

    task automatic push_cell(input int px, input int py, input int pobj);
        x        = 4'(px);
        y        = 4'(py);
        obj_code = 3'(pobj);
        diff     = 1'b1;
        @(negedge clk);
        diff     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle within budget"}, busy, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    int cx[6], cy[6], co[6];
    int len_wait;

    initial begin
        // Reset state
        step(1);
        apply_reset();
        check("rst lcd_data", lcd_data, 8'h00);
        check("rst lcd_dcx", lcd_dcx, 1);
        check("rst lcd_wrx", lcd_wrx, 1);
        check("rst lcd_csx", lcd_csx, 1);
        check("rst busy", busy, 0);
        check("rst overflow", overflow, 0);

        // Single apple at (3,2): latency and full byte stream
        init_done = 1'b1;
        push_cell(3, 2, 3);
        expect_cell(3, 2, 3);
        check("t1 busy after push", busy, 1);
        check("t1 csx idle cycle", lcd_csx, 1);
        step(1);
        check("t1 csx at pop", lcd_csx, 0);
        check("t1 wrx at pop", lcd_wrx, 1);
        step(1);
        check("t1 first wrx fall", lcd_wrx, 0);
        check("t1 first byte", {lcd_dcx, lcd_data}, {1'b0, 8'h2A});
        wait_idle(TXN_CSX_LOW + 50, "t1");
        compare_txn("t1 apple(3,2)");
        check("t1 overflow", overflow, 0);

        // init_done gating; drop mid-transaction does not abort
        init_done = 1'b0;
        cx[0] = $urandom_range(15); cy[0] = $urandom_range(GRID_ROWS - 1); co[0] = $urandom_range(7);
        push_cell(cx[0], cy[0], co[0]);
        expect_cell(cx[0], cy[0], co[0]);
        step(20);
        check("t2 csx held while not init", lcd_csx, 1);
        check("t2 busy while pending", busy, 1);
        check("t2 no bytes while not init", obs_q.size(), 0);
        init_done = 1'b1;
        step(1);
        check("t2 csx at pop", lcd_csx, 0);
        step(1);
        check("t2 wrx fall 2clk after init", lcd_wrx, 0);
        cx[1] = $urandom_range(15); cy[1] = $urandom_range(GRID_ROWS - 1); co[1] = $urandom_range(7);
        push_cell(cx[1], cy[1], co[1]);
        expect_cell(cx[1], cy[1], co[1]);
        step(100);
        init_done = 1'b0;
        len_wait = 0;
        while (lcd_csx !== 1'b1 && len_wait < TXN_CSX_LOW + 50) begin
            @(negedge clk);
            len_wait++;
        end
        check("t2 txn completes after init drop", lcd_csx, 1);
        step(10);
        check("t2 second held csx", lcd_csx, 1);
        check("t2 second pending busy", busy, 1);
        init_done = 1'b1;
        wait_idle(TXN_CSX_LOW + 50, "t2");
        compare_txn("t2 txn0");
        compare_txn("t2 txn1");

        // Six back-to-back diffs: five accepted, one dropped
        for (int i = 0; i < 6; i++) begin
            cx[i] = $urandom_range(15); cy[i] = $urandom_range(GRID_ROWS - 1); co[i] = $urandom_range(7);
        end
        for (int i = 0; i < 6; i++) begin
            x = 4'(cx[i]); y = 4'(cy[i]); obj_code = 3'(co[i]); diff = 1'b1;
            @(negedge clk);
        end
        diff = 1'b0;
        check("t3 overflow set", overflow, 1);
        for (int i = 0; i < 5; i++) expect_cell(cx[i], cy[i], co[i]);
        wait_idle(6 * (TXN_CSX_LOW + 2) + 100, "t3");
        for (int i = 0; i < 5; i++) compare_txn($sformatf("t3 txn%0d", i));
        check("t3 no extra bytes", obs_q.size(), 0);
        check("t3 exactly five txns", csx_len_q.size(), 0);
        check("t3 overflow sticky", overflow, 1);

        // Out-of-range row ignored
        apply_reset();
        check("t4 overflow cleared by rst", overflow, 0);
        push_cell($urandom_range(15), GRID_ROWS + $urandom_range(15 - GRID_ROWS), $urandom_range(7));
        check("t4 busy after y>=rows", busy, 0);
        step(5);
        check("t4 csx after y>=rows", lcd_csx, 1);
        check("t4 overflow after y>=rows", overflow, 0);

        // Reset mid-PIXELS aborts and flushes
        for (int i = 0; i < 6; i++) begin
            x = 4'($urandom_range(15)); y = 4'($urandom_range(GRID_ROWS - 1));
            obj_code = 3'($urandom_range(7)); diff = 1'b1;
            @(negedge clk);
        end
        diff = 1'b0;
        step(300);
        check("t5 overflow before rst", overflow, 1);
        check("t5 csx mid-pixels", lcd_csx, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t5 csx after rst", lcd_csx, 1);
        check("t5 wrx after rst", lcd_wrx, 1);
        check("t5 dcx after rst", lcd_dcx, 1);
        check("t5 data after rst", lcd_data, 8'h00);
        check("t5 busy after rst", busy, 0);
        check("t5 overflow after rst", overflow, 0);
        step(50);
        check("t5 queue lost busy", busy, 0);
        check("t5 queue lost csx", lcd_csx, 1);
        obs_q.delete();
        csx_len_q.delete();

        // Gridline-relevant cells then random cells, with ignored rows mixed in
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                cx[0] = 0; cy[0] = 0; co[0] = 1;
            end else if (i == 1) begin
                cx[0] = 0; cy[0] = 0; co[0] = 4;
            end else begin
                cx[0] = $urandom_range(15); cy[0] = $urandom_range(GRID_ROWS - 1); co[0] = $urandom_range(7);
            end
            push_cell(cx[0], cy[0], co[0]);
            expect_cell(cx[0], cy[0], co[0]);
            step($urandom_range(40, 1));
            push_cell($urandom_range(15), GRID_ROWS + $urandom_range(15 - GRID_ROWS), $urandom_range(7));
            wait_idle(TXN_CSX_LOW + 100, "t6");
            compare_txn($sformatf("t6 cell(%0d,%0d,obj%0d)", cx[0], cy[0], co[0]));
        end
        check("t6 overflow", overflow, 0);
        check("bus hold violations", hold_viol, 0);
        check("wrx strobes outside csx", stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
